// File: rtl/pr_ctrl_sequencer.sv
// Port-gasket partial-reconfiguration sequencer: walks the PR CSR block through the
// reset handshake, start request, bitstream push, status poll and error capture.
module pr_ctrl_sequencer #(
    parameter logic [31:0] BASE_ADDR       = 32'h70000,
    parameter int          ADDR_W          = 20,
    parameter int          ACK_POLL_MAX    = 16,
    parameter int          STATUS_POLL_MAX = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pr_data_valid,
    input  logic [63:0]       pr_data,
    input  logic              pr_data_last,
    output logic              pr_data_ready,
    output logic              csr_req,
    output logic              csr_wr,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [63:0]       csr_wdata,
    input  logic              csr_ack,
    input  logic [63:0]       csr_rdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        result,
    output logic [63:0]       pr_error,
    output logic [31:0]       beat_count
);

    localparam logic [31:0] CTRL_FULL   = BASE_ADDR + 32'h08;
    localparam logic [31:0] STATUS_FULL = BASE_ADDR + 32'h10;
    localparam logic [31:0] DATA_FULL   = BASE_ADDR + 32'h18;
    localparam logic [31:0] ERROR_FULL  = BASE_ADDR + 32'h20;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = CTRL_FULL[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ADDR_STATUS = STATUS_FULL[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ADDR_DATA   = DATA_FULL[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ADDR_ERROR  = ERROR_FULL[ADDR_W-1:0];

    localparam logic [31:0] ACK_LAST    = 32'(ACK_POLL_MAX - 1);
    localparam logic [31:0] STATUS_LAST = 32'(STATUS_POLL_MAX - 1);

    typedef enum logic [3:0] {
        IDLE,
        RST_SET,
        RST_ACK,
        RST_CLR,
        RST_ACK_CLR,
        START_REQ,
        DATA,
        PUSH_DONE,
        STATUS_POLL,
        ERR_RD,
        FAIL,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic              ack_fire;
    logic              poll_last;
    logic              beat_last;
    logic [31:0]       poll_cnt;
    logic              issue;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_addr;
    logic [63:0]       issue_wdata;

    assign ack_fire  = csr_req && csr_ack;
    assign poll_last = (state == STATUS_POLL) ? (poll_cnt == STATUS_LAST)
                                              : (poll_cnt == ACK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Success is tested before the poll limit, so the read that would hit the limit can still pass.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (start) next_state = RST_SET;
            RST_SET:     if (ack_fire) next_state = RST_ACK;
            RST_ACK: begin
                if (ack_fire) begin
                    if (csr_rdata[4])   next_state = RST_CLR;
                    else if (poll_last) next_state = FAIL;
                end
            end
            RST_CLR:     if (ack_fire) next_state = RST_ACK_CLR;
            RST_ACK_CLR: begin
                if (ack_fire) begin
                    if (!csr_rdata[4])  next_state = START_REQ;
                    else if (poll_last) next_state = FAIL;
                end
            end
            START_REQ:   if (ack_fire) next_state = DATA;
            DATA:        if (ack_fire && beat_last) next_state = PUSH_DONE;
            PUSH_DONE:   if (ack_fire) next_state = STATUS_POLL;
            STATUS_POLL: begin
                if (ack_fire) begin
                    if (!csr_rdata[16]) next_state = ERR_RD;
                    else if (poll_last) next_state = FAIL;
                end
            end
            ERR_RD:      if (ack_fire) next_state = FIN;
            FAIL:        next_state = FIN;
            FIN:         next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        issue         = 1'b0;
        issue_wr      = 1'b0;
        issue_addr    = ADDR_CTRL;
        issue_wdata   = 64'h0;
        pr_data_ready = 1'b0;
        busy          = (state != IDLE) && (state != FIN);
        done          = (state == FIN);
        case (state)
            RST_SET: begin
                issue       = !csr_req;
                issue_wr    = 1'b1;
                issue_wdata = 64'h1;
            end
            RST_ACK, RST_ACK_CLR: begin
                issue = !csr_req;
            end
            RST_CLR: begin
                issue    = !csr_req;
                issue_wr = 1'b1;
            end
            START_REQ: begin
                issue       = !csr_req;
                issue_wr    = 1'b1;
                issue_wdata = 64'h1000;
            end
            DATA: begin
                pr_data_ready = !csr_req;
                issue         = pr_data_valid && !csr_req;
                issue_wr      = 1'b1;
                issue_addr    = ADDR_DATA;
                issue_wdata   = pr_data;
            end
            PUSH_DONE: begin
                issue       = !csr_req;
                issue_wr    = 1'b1;
                issue_wdata = 64'h3000;
            end
            STATUS_POLL: begin
                issue      = !csr_req;
                issue_addr = ADDR_STATUS;
            end
            ERR_RD: begin
                issue      = !csr_req;
                issue_addr = ADDR_ERROR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_req    <= 1'b0;
            csr_wr     <= 1'b0;
            csr_addr   <= '0;
            csr_wdata  <= 64'h0;
            beat_last  <= 1'b0;
            poll_cnt   <= 32'h0;
            result     <= 3'd0;
            pr_error   <= 64'h0;
            beat_count <= 32'h0;
        end else begin
            if (ack_fire) begin
                csr_req <= 1'b0;
            end else if (issue) begin
                csr_req   <= 1'b1;
                csr_wr    <= issue_wr;
                csr_addr  <= issue_addr;
                csr_wdata <= issue_wdata;
            end

            if (issue && (state == DATA)) begin
                beat_last <= pr_data_last;
            end

            // Counter restarts on every state change so each polling state gets its own budget.
            if (state != next_state) begin
                poll_cnt <= 32'h0;
            end else if (ack_fire) begin
                poll_cnt <= poll_cnt + 32'd1;
            end

            if ((state == IDLE) && start) begin
                result     <= 3'd0;
                pr_error   <= 64'h0;
                beat_count <= 32'h0;
            end

            if ((state == DATA) && ack_fire && (beat_count != 32'hFFFF_FFFF)) begin
                beat_count <= beat_count + 32'd1;
            end

            if ((state == ERR_RD) && ack_fire) begin
                pr_error <= csr_rdata;
                result   <= (csr_rdata != 64'h0) ? 3'd3 : 3'd0;
            end

            if (ack_fire && (next_state == FAIL)) begin
                result <= (state == STATUS_POLL) ? 3'd2 : 3'd1;
            end
        end
    end

endmodule

// File: doc/pr_ctrl_sequencer.md
Name: pr_ctrl_sequencer

Overview:
- Hardware-side sequencer for the port-gasket partial-reconfiguration (PR) engine. Drives the PR CSR block at BASE_ADDR: DFH +0x0, PR_CTRL +0x8, PR_STATUS +0x10, PR_DATA +0x18, PR_ERROR +0x20.
- Runs the full PR flow through a single-outstanding CSR master port: reset handshake, start request, bitstream push, data-push-complete, status poll, error capture.
- Sits between the bitstream source stream and the port-gasket CSR decoder.

Parameters:
- BASE_ADDR, 32'h70000, byte address of the PR DFH.
- ADDR_W, 20, CSR address width. Addresses are BASE_ADDR+offset truncated to ADDR_W.
- ACK_POLL_MAX, 16, maximum PR_CTRL reads while waiting for a PRReset_ack transition.
- STATUS_POLL_MAX, 1024, maximum PR_STATUS reads while waiting for PR not-busy.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a PR sequence; ignored unless busy=0
- pr_data_valid  in  1  bitstream beat valid
- pr_data  in  64  bitstream beat
- pr_data_last  in  1  final beat of the bitstream
- pr_data_ready  out  1  beat accepted when valid&ready
- csr_req  out  1  CSR request; held until csr_ack
- csr_wr  out  1  1=write, 0=read; stable while csr_req
- csr_addr  out  ADDR_W  CSR byte address; stable while csr_req
- csr_wdata  out  64  write data; stable while csr_req
- csr_ack  in  1  one-cycle completion; csr_rdata valid in the same cycle for reads
- csr_rdata  in  64  read data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- result  out  3  0=OK, 1=reset-ack timeout, 2=status timeout, 3=PR error; held until next start
- pr_error  out  64  captured PR_ERROR value
- beat_count  out  32  beats written to PR_DATA in the current or last sequence

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation: on the cycle rst_n=0 is sampled, csr_req drops and the FSM returns to IDLE. No cleanup writes are issued.
- CSR rules:
  - At most one request outstanding.
  - csr_req rises at least one cycle after entering a state.
  - Address, data and direction are registered.
  - csr_req falls the cycle after csr_ack.
  - csr_ack while csr_req=0 is ignored.
- FSM states, in order:
  - IDLE: on start, clear beat_count, pr_error and result; busy=1 from the next cycle.
  - RST_SET: write PR_CTRL=0x1 (PRReset, bit0).
  - RST_ACK: read PR_CTRL until bit4 (PRReset_ack)=1. Each read counts one poll. Exceeding ACK_POLL_MAX reads → FAIL with result=1.
  - RST_CLR: write PR_CTRL=0x0.
  - RST_ACK_CLR: read PR_CTRL until bit4=0; same limit and failure as RST_ACK.
  - START_REQ: write PR_CTRL=0x1000 (PRStartRequest, bit12).
  - DATA:
    - pr_data_ready=1 only in DATA while csr_req=0.
    - A beat is accepted on valid&ready, latched, and written to PR_DATA. pr_data_ready=0 until csr_ack.
    - beat_count increments on each csr_ack, saturating at 0xFFFF_FFFF.
    - The ack for a beat flagged last → PUSH_DONE.
  - PUSH_DONE: write PR_CTRL=0x3000 (bits 13 and 12).
  - STATUS_POLL: read PR_STATUS until bit16 (PRStatus busy)=0. Exceeding STATUS_POLL_MAX reads → FAIL with result=2.
  - ERR_RD: read PR_ERROR and latch it into pr_error. Nonzero → result=3, else result=0. Then → FIN.
  - FAIL: → FIN, no CSR access.
  - FIN: done=1 for one cycle, busy=0, → IDLE.
- Poll counter: reset on each polling-state entry; compared after each read ack.
- The success condition is checked on the same read that would exceed the limit; success wins.
- start while busy=1 is ignored. start in the FIN cycle is ignored.
- pr_data_valid outside DATA is not consumed.
- A zero-beat bitstream is not supported: the first accepted beat must carry last if the bitstream has one beat.

Test Plan:
1. Nominal flow:
   - Stimulus: start; ack model sets bit4 on the 3rd read and clears it on the 2nd read; 4 beats 0xA0..0xA3 with last on 0xA3; PR_STATUS busy for 5 reads; PR_ERROR=0.
   - Required: CSR trace is W 0x70008=1, R×3, W 0x70008=0, R×2, W 0x70008=0x1000, W 0x70018=A0..A3, W 0x70008=0x3000, R 0x70010×6, R 0x70020; then done pulse, result=0, beat_count=4.
2. Reset-ack timeout: bit4 never set → exactly 16 PR_CTRL reads, then done with result=1, busy=0, and no PR_DATA writes.
3. PR error: PR_ERROR returns 0x5 → result=3, pr_error=0x5.
4. Stream backpressure: pr_data_valid toggles every cycle and csr_ack is delayed 7 cycles → each beat is written exactly once, in order, and pr_data_ready never asserts while csr_req=1.
5. Status limit boundary:
   - Busy clears on read 1024 → result=0.
   - Busy never clears → 1024 reads, then result=2.
6. Reset and start interactions:
   - rst_n=0 for 1 cycle mid-DATA → next cycle csr_req=0, busy=0, all outputs 0.
   - A new start then completes normally.
   - A start pulse while busy=1 has no effect on the trace.
